// File: rtl/psram_burst_responder.sv
// Device-side responder for the synchronous burst PSRAM bus: latches the burst
// address on ADV, waits out the access latency, then sinks/sources a burst.
module psram_burst_responder #(
    parameter int DATA_WIDTH          = 16,
    parameter int PSRAM_ADDRESS_WIDTH = 23,
    parameter int MEM_ADDRESS_WIDTH   = 8,
    parameter int ACCESS_LATENCY      = 1,
    parameter int BURST_SIZE          = 31
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [PSRAM_ADDRESS_WIDTH-1:0] psram_adr,
    input  logic [DATA_WIDTH-1:0]          psram_dat_i,
    output logic [DATA_WIDTH-1:0]          psram_dat_o,
    output logic                           psram_dat_oe,
    input  logic                           psram_ce_n,
    input  logic                           psram_adv_n,
    input  logic                           psram_oe_n,
    input  logic                           psram_we_n,
    output logic                           busy_o,
    output logic [8:0]                     burst_len_o,
    output logic                           err_o
);

    localparam int         LAT_W       = $clog2(ACCESS_LATENCY + 2);
    localparam int         DEPTH       = 1 << MEM_ADDRESS_WIDTH;
    localparam logic [8:0] BURST_WORDS = 9'(BURST_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATENCY,
        S_BURST
    } state_t;

    state_t                       state_q, state_d;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic                         wr_q, wr_d;
    logic [LAT_W-1:0]             lat_cnt_q, lat_cnt_d;
    logic [8:0]                   burst_len_q, burst_len_d;
    logic                         err_q, err_d;
    logic [DATA_WIDTH-1:0]        dat_q, dat_d;
    logic                         mem_we;
    logic                         full;
    logic                         viol;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Upper bus address bits are deliberately ignored.
    logic unused_adr;
    assign unused_adr = ^psram_adr[PSRAM_ADDRESS_WIDTH-1:MEM_ADDRESS_WIDTH];

    assign addr_inc = addr_q + MEM_ADDRESS_WIDTH'(1);
    assign full     = (burst_len_q == BURST_WORDS);
    // Only judged while selected, so the initiator may release we_n with ce_n.
    assign viol     = !psram_adv_n || (psram_we_n == wr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        lat_cnt_d   = lat_cnt_q;
        burst_len_d = burst_len_q;
        err_d       = err_q;
        dat_d       = dat_q;
        mem_we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!psram_ce_n && !psram_adv_n) begin
                    state_d     = S_LATENCY;
                    addr_d      = psram_adr[MEM_ADDRESS_WIDTH-1:0];
                    wr_d        = !psram_we_n;
                    lat_cnt_d   = '0;
                    burst_len_d = '0;
                end
            end
            S_LATENCY: begin
                if (psram_ce_n) begin
                    state_d = S_IDLE;
                end else begin
                    if (viol) err_d = 1'b1;
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(ACCESS_LATENCY)) begin
                        state_d = S_BURST;
                        // Word 0 must be on the bus as BURST is entered.
                        if (!wr_q) dat_d = mem[addr_q];
                    end
                end
            end
            S_BURST: begin
                if (psram_ce_n) begin
                    state_d = S_IDLE;
                end else begin
                    if (viol) err_d = 1'b1;
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        burst_len_d = burst_len_q + 9'd1;
                        addr_d      = addr_inc;
                        if (wr_q) mem_we = 1'b1;
                        else      dat_d  = mem[addr_inc];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            lat_cnt_q   <= '0;
            burst_len_q <= '0;
            err_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_len_q <= burst_len_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
        end
    end

    // Array contents survive reset; writes are simply suppressed while it is held.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) mem[addr_q] <= psram_dat_i;
    end

    assign psram_dat_o  = dat_q;
    assign psram_dat_oe = (state_q == S_BURST) && !wr_q && !psram_oe_n;
    assign busy_o       = (state_q != S_IDLE);
    assign burst_len_o  = burst_len_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_psram_burst_responder.sv
// Transaction-level model of the PSRAM responder: expected outputs are derived
// from burst start time, word index and a model memory, checked every cycle.
module tb_psram_burst_responder;

    localparam int LAT   = 1;
    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] psram_adr;
    logic [15:0] psram_dat_i;
    logic [15:0] psram_dat_o;
    logic        psram_dat_oe;
    logic        ce_n, adv_n, oe_n, we_n;
    logic        busy_o;
    logic [8:0]  burst_len_o;
    logic        err_o;

    psram_burst_responder #(
        .DATA_WIDTH(16), .PSRAM_ADDRESS_WIDTH(23), .MEM_ADDRESS_WIDTH(8),
        .ACCESS_LATENCY(LAT), .BURST_SIZE(WORDS - 1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .psram_adr(psram_adr),
        .psram_dat_i(psram_dat_i), .psram_dat_o(psram_dat_o), .psram_dat_oe(psram_dat_oe),
        .psram_ce_n(ce_n), .psram_adv_n(adv_n), .psram_oe_n(oe_n), .psram_we_n(we_n),
        .busy_o(busy_o), .burst_len_o(burst_len_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [15:0] m_mem [256];
    bit          m_vld [256];
    bit          m_busy, m_err, m_rd_burst, m_dat_chk;
    int          m_len;
    logic [15:0] m_dat;
    logic [15:0] cap_q [$];

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic cmp();
        @(negedge clk);
        check("busy", 32'(busy_o), 32'(m_busy));
        check("burst_len", 32'(burst_len_o), 32'(m_len));
        check("err", 32'(err_o), 32'(m_err));
        check("dat_oe", 32'(psram_dat_oe), 32'(m_rd_burst && !oe_n));
        if (m_dat_chk) begin
            check("dat_o", 32'(psram_dat_o), 32'(m_dat));
            cap_q.push_back(psram_dat_o);
        end
    endtask

    function automatic void model_load(int idx);
        m_dat     = m_mem[idx];
        m_dat_chk = m_vld[idx];
    endfunction

    // base < 0 selects random data; *_at < 0 disables that event.
    task automatic burst(input logic [22:0] adr, input bit wr, input int n, input int base,
                         input bit abort_lat, input int viol_at, input int wev_at, input int rst_at);
        int          a;
        int          cnt;
        logic [15:0] d;
        a   = int'(adr[7:0]);
        cnt = 0;
        ce_n = 1'b0; adv_n = 1'b0; psram_adr = adr; we_n = !wr; oe_n = 1'($urandom_range(0, 1));
        tick();
        m_busy = 1; m_len = 0; m_dat_chk = 0; m_rd_burst = 0;
        cmp();
        adv_n = 1'b1; psram_adr = 23'($urandom);
        if (abort_lat) begin
            ce_n = 1'b1;
            tick();
            m_busy = 0;
            cmp();
            return;
        end
        for (int i = 0; i <= LAT; i++) begin
            oe_n = 1'($urandom_range(0, 1));
            tick();
            if (i == LAT) begin
                m_rd_burst = !wr;
                if (!wr) model_load(a);
            end
            cmp();
        end
        for (int j = 0; j < n; j++) begin
            d = (base < 0) ? 16'($urandom) : 16'(base + j);
            psram_dat_i = d;
            oe_n  = 1'($urandom_range(0, 1));
            adv_n = (j == viol_at) ? 1'b0 : 1'b1;
            we_n  = (j == wev_at) ? wr : !wr;
            rst_n = (j == rst_at) ? 1'b0 : 1'b1;
            tick();
            if (j == rst_at) begin
                m_busy = 0; m_len = 0; m_err = 0; m_rd_burst = 0; m_dat = 16'h0; m_dat_chk = 1;
                cmp();
                rst_n = 1'b1; adv_n = 1'b1; we_n = !wr; ce_n = 1'b1;
                tick();
                cmp();
                m_dat_chk = 0;
                return;
            end
            if (cnt < WORDS) begin
                if (wr) begin
                    m_mem[(a + cnt) % 256] = d;
                    m_vld[(a + cnt) % 256] = 1;
                end
                cnt++;
            end else begin
                m_err = 1;
            end
            if (j == viol_at || j == wev_at) m_err = 1;
            m_len = cnt;
            if (!wr) model_load((a + cnt) % 256);
            cmp();
        end
        ce_n = 1'b1; adv_n = 1'b1; we_n = !wr;
        tick();
        m_busy = 0; m_rd_burst = 0; m_dat_chk = 0;
        cmp();
    endtask

    initial begin
        rst_n = 1'b0; ce_n = 1'b0; adv_n = 1'b0; oe_n = 1'b1; we_n = 1'b1;
        psram_adr = '0; psram_dat_i = '0;
        m_busy = 0; m_err = 0; m_len = 0; m_rd_burst = 0; m_dat = 16'h0; m_dat_chk = 1;

        // Reset held 3 edges while a request is presented
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp();
        end
        rst_n = 1'b1; ce_n = 1'b1; adv_n = 1'b1;
        tick();
        cmp();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_len", 32'(burst_len_o), 32'd0);
        check("rst_oe", 32'(psram_dat_oe), 32'd0);
        m_dat_chk = 0;

        // Full write then read at 0x10
        burst(23'h000010, 1'b1, WORDS, 16'h1000, 0, -1, -1, -1);
        check("wr_len32", 32'(burst_len_o), 32'd32);
        cap_q.delete();
        burst(23'h000010, 1'b0, WORDS, -1, 0, -1, -1, -1);
        check("rd_count", 32'(cap_q.size()), 32'd32);
        check("rd_w0", 32'(cap_q[0]), 32'h1000);
        check("rd_w17", 32'(cap_q[17]), 32'h1011);
        check("rd_w31", 32'(cap_q[31]), 32'h101F);
        check("rd_len32", 32'(burst_len_o), 32'd32);
        check("rd_err0", 32'(err_o), 32'd0);

        // Address wrap; upper address bits set to show they are ignored
        burst(23'h4000FE, 1'b1, 4, 16'h2000, 0, -1, -1, -1);
        cap_q.delete();
        burst(23'h7F00FE, 1'b0, 3, -1, 0, -1, -1, -1);
        check("wrap_w0", 32'(cap_q[0]), 32'h2000);
        check("wrap_w2", 32'(cap_q[2]), 32'h2002);
        check("wrap_w3", 32'(cap_q[3]), 32'h2003);

        // Early termination: in LATENCY, then after 5 words
        burst(23'h000050, 1'b1, 0, 0, 1, -1, -1, -1);
        check("abort_len", 32'(burst_len_o), 32'd0);
        burst(23'h000050, 1'b1, 5, 16'h5000, 0, -1, -1, -1);
        check("early_len", 32'(burst_len_o), 32'd5);
        check("early_err", 32'(err_o), 32'd0);

        // Overrun: word 32 at 0x60 must survive
        burst(23'h000060, 1'b1, 1, 16'hBEEF, 0, -1, -1, -1);
        burst(23'h000040, 1'b1, WORDS + 2, 16'h3000, 0, -1, -1, -1);
        check("ovr_err", 32'(err_o), 32'd1);
        check("ovr_len", 32'(burst_len_o), 32'd32);
        cap_q.delete();
        burst(23'h000040, 1'b0, WORDS, -1, 0, -1, -1, -1);
        check("ovr_w31", 32'(cap_q[31]), 32'h301F);
        check("ovr_keep", 32'(cap_q[32]), 32'hBEEF);

        // ADV violation then reset mid-burst
        burst(23'h000080, 1'b1, 8, 16'h4000, 0, 1, -1, 3);
        check("mrst_err", 32'(err_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        cap_q.delete();
        burst(23'h000010, 1'b0, 4, -1, 0, -1, -1, -1);
        check("keep_w1", 32'(cap_q[1]), 32'h1001);
        cap_q.delete();
        burst(23'h000080, 1'b0, 3, -1, 0, -1, -1, -1);
        check("keep_w2", 32'(cap_q[2]), 32'h4002);
        check("keep_w3", 32'(m_vld[8'h83]), 32'd0);

        // Fill the whole array, then random traffic
        for (int b = 0; b < 8; b++)
            burst(23'(b * 32), 1'b1, WORDS, -1, 0, -1, -1, -1);
        for (int t = 0; t < 40; t++) begin
            int n;
            int va, wa, ra;
            n  = $urandom_range(0, WORDS + 4);
            va = ($urandom_range(0, 5) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            wa = ($urandom_range(0, 5) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            ra = ($urandom_range(0, 9) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            burst(23'($urandom), 1'($urandom_range(0, 1)), n, -1,
                  ($urandom_range(0, 7) == 0), va, wa, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
